seg_scan_mux: RTL and testbench

- Parametrised multiplexed 7-segment driver for an N-digit common-scan display.
- Holds a committed hex value per digit. Accepts new values over a valid/ready handshake and commits them only at frame boundaries, so a frame never shows a mix of old and new values.
- Also provides per-digit decimal points, leading-zero blanking and PWM brightness.
- Sits between the counter/datapath logic and the board's select and segment pins.

---
 rtl/seg_scan_mux.sv | 201 ++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Multiplexed N-digit 7-segment scanner with frame-synchronous tear-free loads,
// leading-zero blanking and PWM brightness. Optional blink support: SEG_BLINK_EN.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 200000,
  parameter int BRIGHT_W   = 4,
  parameter int BLINK_DIV  = 50000000
) (
  input  logic                    fastclk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    lz_blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   select,
  output logic [7:0]              hex_display,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(SCAN_DIV + 1);
  localparam int STEP  = SCAN_DIV >> BRIGHT_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]        slot_cnt_reg;
  logic [IDX_W-1:0]        scan_idx_reg;
  logic [BRIGHT_W-1:0]     bright_hold_reg;
  logic [BRIGHT_W-1:0]     bright_eff;
  logic [CNT_W-1:0]        on_len;
  logic                    slot_start;
  logic                    slot_wrap;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] cur_data_reg, pend_data_reg;
  logic [NUM_DIGITS-1:0]   cur_dp_reg, pend_dp_reg;
  logic                    pending_full_reg;
  logic                    accept;

  logic [3:0]              nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_vec;
  logic                    lz_run;
  logic                    blink_off;
  logic                    drive_on;
  logic [3:0]              cur_nib;
  logic [7:0]              seg_code;
  logic [NUM_DIGITS-1:0]   select_next;
  logic [7:0]              hex_next;
  logic [NUM_DIGITS-1:0]   select_reg;
  logic [7:0]              hex_reg;
  logic                    frame_tick_reg;

  assign slot_start = (slot_cnt_reg == '0);
  assign slot_wrap  = (slot_cnt_reg == SLOT_LAST);
  assign frame_end  = slot_wrap && (scan_idx_reg == '0);

  // Brightness is taken live on the first cycle of a slot and held for the rest.
  assign bright_eff = slot_start ? brightness : bright_hold_reg;
  assign on_len     = CNT_W'((int'(bright_eff) + 1) * STEP);

  always_ff @(posedge fastclk) begin
    if (reset) begin
      slot_cnt_reg    <= '0;
      scan_idx_reg    <= LAST_IDX;
      bright_hold_reg <= '0;
    end else begin
      bright_hold_reg <= bright_eff;
      if (slot_wrap) begin
        slot_cnt_reg <= '0;
        scan_idx_reg <= (scan_idx_reg == '0) ? LAST_IDX : scan_idx_reg - IDX_W'(1);
      end else begin
        slot_cnt_reg <= slot_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Accept and commit are exclusive: accept needs an empty buffer, commit a full one.
  assign accept     = load_valid && !pending_full_reg;
  assign load_ready = !pending_full_reg;

  always_ff @(posedge fastclk) begin
    if (reset) begin
      pending_full_reg <= 1'b0;
      pend_data_reg    <= '0;
      pend_dp_reg      <= '0;
      cur_data_reg     <= '0;
      cur_dp_reg       <= '0;
    end else if (accept) begin
      pending_full_reg <= 1'b1;
      pend_data_reg    <= load_data;
      pend_dp_reg      <= load_dp;
    end else if (frame_end && pending_full_reg) begin
      pending_full_reg <= 1'b0;
      cur_data_reg     <= pend_data_reg;
      cur_dp_reg       <= pend_dp_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib[gi] = cur_data_reg[4*gi +: 4];
  end

  // Blanking runs from the leftmost digit down and stops at the first visible one.
  always_comb begin
    lz_vec = '0;
    lz_run = lz_blank;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run    = lz_run && (nib[i] == 4'h0) && !cur_dp_reg[i];
      lz_vec[i] = lz_run;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BL_W = $clog2(BLINK_DIV);
  localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_DIV - 1);

  logic [BL_W-1:0] blink_cnt_reg;
  logic            blink_phase_reg;
  logic            blink_hold_reg;
  logic            blink_eff;

  // Phase is latched at slot start so a blinking digit stays dark for a whole slot.
  assign blink_eff = slot_start ? blink_phase_reg : blink_hold_reg;
  assign blink_off = !blink_eff && blink_mask[scan_idx_reg];

  always_ff @(posedge fastclk) begin
    if (reset) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
      blink_hold_reg  <= 1'b1;
    end else begin
      blink_hold_reg <= blink_eff;
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= !blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BL_W'(1);
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, 1'(BLINK_DIV % 2)};
  assign blink_off    = 1'b0;
`endif

  assign cur_nib  = nib[scan_idx_reg];
  assign drive_on = (slot_cnt_reg < on_len) && !lz_vec[scan_idx_reg] && !blink_off;

  always_comb begin
    seg_code = 8'h00;
    case (cur_nib)
      4'h0: seg_code = 8'hFC;
      4'h1: seg_code = 8'h60;
      4'h2: seg_code = 8'hDA;
      4'h3: seg_code = 8'hF2;
      4'h4: seg_code = 8'h66;
      4'h5: seg_code = 8'hB6;
      4'h6: seg_code = 8'hBE;
      4'h7: seg_code = 8'hE0;
      4'h8: seg_code = 8'hFE;
      4'h9: seg_code = 8'hF6;
      4'hA: seg_code = 8'hEE;
      4'hB: seg_code = 8'h3E;
      4'hC: seg_code = 8'h9C;
      4'hD: seg_code = 8'h7A;
      4'hE: seg_code = 8'h9E;
      4'hF: seg_code = 8'h8E;
      default: seg_code = 8'h00;
    endcase
  end

  always_comb begin
    select_next = '0;
    hex_next    = 8'h00;
    if (drive_on) begin
      select_next[scan_idx_reg] = 1'b1;
      hex_next = seg_code | {7'b0, cur_dp_reg[scan_idx_reg]};
    end
  end

  always_ff @(posedge fastclk) begin
    if (reset) begin
      select_reg     <= '0;
      hex_reg        <= 8'h00;
      frame_tick_reg <= 1'b0;
    end else begin
      select_reg     <= select_next;
      hex_reg        <= hex_next;
      frame_tick_reg <= frame_end;
    end
  end

  assign select      = select_reg;
  assign hex_display = hex_reg;
  assign frame_tick  = frame_tick_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (4 digits, 16-cycle slots, 4-bit brightness).
module tb_seg_scan_mux;

  logic        fastclk;
  logic        reset;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic        load_valid;
  logic        load_ready;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic [3:0]  blink_mask;
  logic [3:0]  select;
  logic [7:0]  hex_display;
  logic        frame_tick;

  int   checks = 0;
  int   errors = 0;
  logic first_ready;

  seg_scan_mux #(
    .NUM_DIGITS(4),
    .SCAN_DIV(16),
    .BRIGHT_W(4),
    .BLINK_DIV(128)
  ) dut (
    .fastclk(fastclk),
    .reset(reset),
    .load_data(load_data),
    .load_dp(load_dp),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .lz_blank(lz_blank),
    .brightness(brightness),
    .blink_mask(blink_mask),
    .select(select),
    .hex_display(hex_display),
    .frame_tick(frame_tick)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  bright;
    logic [7:0]  e3, e2, e1, e0;
    int          on_n;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(negedge fastclk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end else begin
      $display("ok   %s value=%0h", nm, act);
    end
  endtask

  // Observes one 64-cycle frame starting at the next sample; expected 0 = blank digit.
  task automatic check_frame(input string nm, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0, input int on_n);
    logic [7:0] ex [4];
    int on_cnt;
    int bad;
    ex[3] = e3; ex[2] = e2; ex[1] = e1; ex[0] = e0;
    for (int d = 3; d >= 0; d--) begin
      on_cnt = 0;
      bad = 0;
      for (int j = 0; j < 16; j++) begin
        tick();
        if (d == 3 && j == 0) first_ready = load_ready;
        if (frame_tick != ((d == 0) && (j == 15))) bad++;
        if (select == 4'b0000) begin
          if (hex_display != 8'h00) bad++;
        end else if (select == 4'(1 << d) && ex[d] != 8'h00 && hex_display == ex[d] && j < on_n) begin
          on_cnt++;
        end else begin
          bad++;
        end
      end
      chk($sformatf("%s_d%0d_on", nm, d), on_cnt, (ex[d] != 8'h00) ? on_n : 0);
      chk($sformatf("%s_d%0d_bad", nm, d), bad, 0);
    end
  endtask

  task automatic wait_frame_tick(input string nm);
    int n;
    n = 0;
    while (!frame_tick && n < 200) begin
      tick();
      n++;
    end
    if (!frame_tick) chk({nm, "_ft_timeout"}, 0, 1);
  endtask

  task automatic do_load(input string nm, input logic [15:0] d, input logic [3:0] p);
    int n;
    n = 0;
    while (!load_ready && n < 200) begin
      tick();
      n++;
    end
    load_data  = d;
    load_dp    = p;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk({nm, "_accept"}, load_ready, 0);
  endtask

  initial begin
    int bad;
    int found;
    logic prev_ready;

    vecs[0] = '{16'h0000, 4'b0000, 1'b0, 4'd15, 8'hFC, 8'hFC, 8'hFC, 8'hFC, 16};
    vecs[1] = '{16'h2019, 4'b0000, 1'b0, 4'd15, 8'hDA, 8'hFC, 8'h60, 8'hF6, 16};
    vecs[2] = '{16'h0050, 4'b0000, 1'b1, 4'd15, 8'h00, 8'h00, 8'hB6, 8'hFC, 16};
    vecs[3] = '{16'h0000, 4'b0000, 1'b1, 4'd15, 8'h00, 8'h00, 8'h00, 8'hFC, 16};
    vecs[4] = '{16'h1800, 4'b0100, 1'b0, 4'd3,  8'h60, 8'hFF, 8'hFC, 8'hFC, 4};
    vecs[5] = '{16'hABCD, 4'b0000, 1'b1, 4'd7,  8'hEE, 8'h3E, 8'h9C, 8'h7A, 8};
    vecs[6] = '{16'h00E0, 4'b1000, 1'b1, 4'd0,  8'hFD, 8'hFC, 8'h9E, 8'hFC, 1};
    vecs[7] = '{16'h0F00, 4'b0000, 1'b1, 4'd15, 8'h00, 8'h8E, 8'hFC, 8'hFC, 16};
    vecs[8] = '{16'h567E, 4'b0001, 1'b0, 4'd14, 8'hB6, 8'hBE, 8'hE0, 8'h9F, 15};

    reset      = 1'b1;
    load_data  = '0;
    load_dp    = '0;
    load_valid = 1'b0;
    lz_blank   = 1'b0;
    brightness = 4'hF;
    blink_mask = '0;
    repeat (3) tick();
    chk("rst_select", select, 0);
    chk("rst_hex", hex_display, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_ready", load_ready, 1);

    // Reset scan: first sample after release already shows digit 3.
    reset = 1'b0;
    check_frame("scan0", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 16);
    check_frame("scan1", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 16);

    // Tear-free load applied mid-frame.
    repeat (20) tick();
    load_data  = 16'h2019;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("tf_ready_drop", load_ready, 0);
    found = 0;
    bad = 0;
    prev_ready = load_ready;
    for (int i = 0; i < 200 && found == 0; i++) begin
      prev_ready = load_ready;
      tick();
      if (frame_tick) found = 1;
      if (select != 4'b0000 && hex_display != 8'hFC) bad++;
    end
    chk("tf_found_tick", found, 1);
    chk("tf_old_shown", bad, 0);
    chk("tf_ready_before_tick", prev_ready, 0);
    check_frame("tf_new", 8'hDA, 8'hFC, 8'h60, 8'hF6, 16);
    chk("tf_ready_after", first_ready, 1);

    // Accept in the boundary cycle: commit waits a full frame.
    repeat (63) tick();
    chk("col_ready_pre", load_ready, 1);
    load_data  = 16'h1234;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("col_tick", frame_tick, 1);
    chk("col_accept", load_ready, 0);
    check_frame("col_old", 8'hDA, 8'hFC, 8'h60, 8'hF6, 16);
    chk("col_old_ready", first_ready, 0);
    check_frame("col_new", 8'h60, 8'hDA, 8'hF2, 8'h66, 16);
    chk("col_new_ready", first_ready, 1);

    foreach (vecs[k]) begin
      lz_blank   = vecs[k].lz;
      brightness = vecs[k].bright;
      do_load($sformatf("v%0d", k), vecs[k].data, vecs[k].dp);
      wait_frame_tick($sformatf("v%0d", k));
      check_frame($sformatf("v%0d", k), vecs[k].e3, vecs[k].e2, vecs[k].e1, vecs[k].e0,
                  vecs[k].on_n);
    end

    // Reset while a load is pending discards it.
    lz_blank   = 1'b0;
    brightness = 4'hF;
    do_load("rl", 16'h8888, 4'b0000);
    reset = 1'b1;
    tick();
    chk("rl_ready", load_ready, 1);
    chk("rl_select", select, 0);
    tick();
    reset = 1'b0;
    check_frame("rl_f0", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 16);
    check_frame("rl_f1", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 16);

`ifdef SEG_BLINK_EN
    blink_mask = 4'b0001;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check_frame("bl_f0", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 16);
    check_frame("bl_f1", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 16);
    check_frame("bl_f2", 8'hFC, 8'hFC, 8'hFC, 8'h00, 16);
    check_frame("bl_f3", 8'hFC, 8'hFC, 8'hFC, 8'h00, 16);
    check_frame("bl_f4", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 16);
    check_frame("bl_f5", 8'hFC, 8'hFC, 8'hFC, 8'hFC, 16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
